sprite_anim_mapper: RTL and testbench

//  Positioned, animated, scaled sprite renderer for the VGA path. Maps DrawX/DrawY to
//  an address in a multi-frame sprite ROM; external palette turns ROM index into 4-bit RGB.

---
 rtl/sprite_anim_mapper_if.sv | 18 +
 rtl/sprite_anim_mapper.sv | 173 +++++++++++++++++
 tb/tb_sprite_anim_mapper.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_anim_mapper_if.sv
// Sprite ROM / palette bus between sprite_anim_mapper (master) and the ROM + palette (slave).
// rom_q must be valid in the cycle the registered rom_address is presented; pal_* are combinational from pal_index.
interface sprite_anim_mapper_if #(
  parameter int ADDR_W = 14,
  parameter int IDX_W  = 4
);
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_r;
  logic [3:0]        pal_g;
  logic [3:0]        pal_b;

  modport master (output rom_address, output pal_index,
                  input rom_q, input pal_r, input pal_g, input pal_b);
  modport slave  (input rom_address, input pal_index,
                  output rom_q, output pal_r, output pal_g, output pal_b);
endinterface

// File: rtl/sprite_anim_mapper.sv
// Positioned, scaled, animated sprite renderer: DrawX/DrawY -> ROM texel -> palette RGB + opaque.
// Optional macro SPRITE_FLIP_EN adds a flip_h port that mirrors the sprite horizontally.
module sprite_anim_mapper #(
  parameter int SPR_W      = 40,
  parameter int SPR_H      = 66,
  parameter int N_FRAMES   = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W     = $clog2(SPR_W*SPR_H*N_FRAMES)
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic [9:0] sprite_x,
  input  logic [9:0] sprite_y,
  input  logic       frame_tick,
  input  logic       anim_start,
  input  logic       anim_loop,
`ifdef SPRITE_FLIP_EN
  input  logic       flip_h,
`endif
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       opaque,
  output logic       anim_done,
  sprite_anim_mapper_if.master mem
);

  localparam int FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(N_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic signed [10:0] BOX_W_S = 11'(SPR_W << SCALE_LOG2);
  localparam logic signed [10:0] BOX_H_S = 11'(SPR_H << SCALE_LOG2);

  function automatic logic [ADDR_W-1:0] texel_addr(input logic [FRAME_W-1:0] f,
                                                   input logic [ADDR_W-1:0]  row,
                                                   input logic [ADDR_W-1:0]  col);
    return ADDR_W'(f) * ADDR_W'(SPR_W * SPR_H) + row * ADDR_W'(SPR_W) + col;
  endfunction

  typedef enum logic [1:0] {IDLE, PLAY, DONE} anim_state_t;

  anim_state_t        state_q, state_n;
  logic [FRAME_W-1:0] frame_q, frame_n;
  logic [HOLD_W-1:0]  hold_q, hold_n;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      frame_q <= frame_n;
      hold_q  <= hold_n;
    end
  end

  // A start pulse outranks a coincident tick; anim_loop is only looked at on a frame advance.
  always_comb begin
    state_n = state_q;
    frame_n = frame_q;
    hold_n  = hold_q;
    if (anim_start) begin
      state_n = PLAY;
      frame_n = '0;
      hold_n  = '0;
    end else if (state_q == PLAY && frame_tick) begin
      if (hold_q == HOLD_LAST) begin
        hold_n = '0;
        if (frame_q == LAST_FRAME) begin
          if (anim_loop) frame_n = '0;
          else           state_n = DONE;
        end else begin
          frame_n = frame_q + 1'b1;
          if (frame_n == LAST_FRAME && !anim_loop) state_n = DONE;
        end
      end else begin
        hold_n = hold_q + 1'b1;
      end
    end
  end

  assign anim_done = (state_q == DONE);

  // Position and displayed frame change only at pixel (0,0); that pixel already uses the new values.
  logic               at_origin, armed_q, armed_eff;
  logic [9:0]         pos_x_q, pos_y_q, pos_x_eff, pos_y_eff;
  logic [FRAME_W-1:0] frame_disp_q, frame_eff;
  logic               flip_q, flip_eff;

  assign at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign armed_eff = armed_q | at_origin;
  assign pos_x_eff = at_origin ? sprite_x : pos_x_q;
  assign pos_y_eff = at_origin ? sprite_y : pos_y_q;
  assign frame_eff = at_origin ? frame_q  : frame_disp_q;
`ifdef SPRITE_FLIP_EN
  assign flip_eff  = at_origin ? flip_h   : flip_q;
`else
  assign flip_eff  = 1'b0;
`endif

  always_ff @(posedge vga_clk) begin
    if (at_origin) begin
      pos_x_q      <= sprite_x;
      pos_y_q      <= sprite_y;
      frame_disp_q <= frame_q;
      flip_q       <= flip_eff;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset)          armed_q <= 1'b0;
    else if (at_origin) armed_q <= 1'b1;
  end

  // S0: box test and texel address
  logic signed [10:0] dx_p0, dy_p0;
  logic               hit_p0;
  logic [ADDR_W-1:0]  col_p0, row_p0;

  assign dx_p0  = $signed({1'b0, DrawX}) - $signed({1'b0, pos_x_eff});
  assign dy_p0  = $signed({1'b0, DrawY}) - $signed({1'b0, pos_y_eff});
  assign hit_p0 = armed_eff && (dx_p0 >= 11'sd0) && (dx_p0 < BOX_W_S) &&
                  (dy_p0 >= 11'sd0) && (dy_p0 < BOX_H_S);
  assign row_p0 = ADDR_W'(dy_p0[9:0] >> SCALE_LOG2);
  assign col_p0 = flip_eff ? ADDR_W'(SPR_W - 1) - ADDR_W'(dx_p0[9:0] >> SCALE_LOG2)
                           : ADDR_W'(dx_p0[9:0] >> SCALE_LOG2);

  logic [ADDR_W-1:0] addr_p1;
  logic              hit_p1, vld_p1;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      addr_p1 <= '0;
      hit_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      addr_p1 <= hit_p0 ? texel_addr(frame_eff, row_p0, col_p0) : '0;
      hit_p1  <= hit_p0;
      vld_p1  <= blank;
    end
  end

  assign mem.rom_address = addr_p1;

  // S1: ROM data -> palette -> output register
  logic opq_p1;

  assign mem.pal_index = mem.rom_q;
  assign opq_p1 = hit_p1 && vld_p1 && (mem.rom_q != IDX_W'(TRANSP_IDX));

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      opaque <= 1'b0;
      red    <= 4'h0;
      green  <= 4'h0;
      blue   <= 4'h0;
    end else begin
      opaque <= opq_p1;
      red    <= opq_p1 ? mem.pal_r : 4'h0;
      green  <= opq_p1 ? mem.pal_g : 4'h0;
      blue   <= opq_p1 ? mem.pal_b : 4'h0;
    end
  end

endmodule

// File: tb/tb_sprite_anim_mapper.sv
// Bench for sprite_anim_mapper: two instances (scale 1x and 2x) share stimulus; a behavioural
// model of the sprite rules predicts every output each cycle, plus table vectors and hand sequences.
module tb_sprite_anim_mapper;
  localparam int FW = 40, FH = 66, NF = 4, HOLD = 6, AW = 14;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, sprite_x = '0, sprite_y = '0;
  logic       blank = 1'b1, frame_tick = 1'b0, anim_start = 1'b0, anim_loop = 1'b0;
  logic       flip_h = 1'b0, force_transp = 1'b0;
  logic [3:0] red0, green0, blue0, red1, green1, blue1;
  logic       opaque0, opaque1, done0, done1;

  int n_cmp = 0, n_bad = 0;

  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] rom_fn(input int a);
    return 4'(((a * 5 + 3) % 15) + 1);
  endfunction

  function automatic logic [11:0] pal_fn(input logic [3:0] idx);
    return {idx, idx ^ 4'h5, ~idx};
  endfunction

  sprite_anim_mapper_if #(.ADDR_W(AW), .IDX_W(4)) bus0 ();
  sprite_anim_mapper_if #(.ADDR_W(AW), .IDX_W(4)) bus1 ();

  assign bus0.rom_q = force_transp ? 4'h0 : rom_fn(int'(bus0.rom_address));
  assign bus1.rom_q = force_transp ? 4'h0 : rom_fn(int'(bus1.rom_address));
  assign {bus0.pal_r, bus0.pal_g, bus0.pal_b} = pal_fn(bus0.pal_index);
  assign {bus1.pal_r, bus1.pal_g, bus1.pal_b} = pal_fn(bus1.pal_index);

  sprite_anim_mapper #(.SCALE_LOG2(0)) dut0 (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_tick(frame_tick),
    .anim_start(anim_start), .anim_loop(anim_loop),
`ifdef SPRITE_FLIP_EN
    .flip_h(flip_h),
`endif
    .red(red0), .green(green0), .blue(blue0), .opaque(opaque0), .anim_done(done0),
    .mem(bus0.master));

  sprite_anim_mapper #(.SCALE_LOG2(1)) dut1 (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_tick(frame_tick),
    .anim_start(anim_start), .anim_loop(anim_loop),
`ifdef SPRITE_FLIP_EN
    .flip_h(flip_h),
`endif
    .red(red1), .green(green1), .blue(blue1), .opaque(opaque1), .anim_done(done1),
    .mem(bus1.master));

  // Reference model state
  bit          playing = 0, done = 0;
  int          a_frame = 0, a_ticks = 0;
  bit          armed = 0, lat_flip = 0;
  int          lat_x = 0, lat_y = 0, lat_f = 0;
  int          m_addr[2] = '{0, 0};
  bit          m_hit[2] = '{0, 0};
  bit          m_opq[2] = '{0, 0};
  logic [11:0] m_rgb[2] = '{12'h0, 12'h0};
  bit          m_blk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int x, input int y, input bit blk, input bit tk, input bit st);
    if (Reset) begin
      playing = 0; done = 0; a_frame = 0; a_ticks = 0; armed = 0; m_blk = 0;
      for (int k = 0; k < 2; k++) begin
        m_addr[k] = 0; m_hit[k] = 0; m_opq[k] = 0; m_rgb[k] = '0;
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      logic [3:0] idx;
      idx = force_transp ? 4'h0 : rom_fn(m_addr[k]);
      m_opq[k] = m_hit[k] && m_blk && (idx != 4'h0);
      m_rgb[k] = m_opq[k] ? pal_fn(idx) : 12'h0;
    end
    if (x == 0 && y == 0) begin
      lat_x = int'(sprite_x); lat_y = int'(sprite_y); lat_f = a_frame; armed = 1;
`ifdef SPRITE_FLIP_EN
      lat_flip = flip_h;
`else
      lat_flip = 0;
`endif
    end
    for (int k = 0; k < 2; k++) begin
      int dx, dy, col;
      dx = x - lat_x; dy = y - lat_y;
      m_hit[k] = armed && dx >= 0 && dx < (FW << k) && dy >= 0 && dy < (FH << k);
      col = dx >> k;
      if (lat_flip) col = FW - 1 - col;
      m_addr[k] = m_hit[k] ? lat_f * FW * FH + (dy >> k) * FW + col : 0;
    end
    m_blk = blk;
    if (st) begin
      playing = 1; done = 0; a_frame = 0; a_ticks = 0;
    end else if (playing && !done && tk) begin
      a_ticks++;
      if (a_ticks % HOLD == 0) begin
        if (anim_loop) a_frame = (a_frame + 1) % NF;
        else if (a_frame < NF - 1) a_frame++;
        if (!anim_loop && a_frame == NF - 1) done = 1;
      end
    end
  endtask

  task automatic cyc(input int x, input int y, input bit blk, input bit tk, input bit st);
    DrawX = 10'(x); DrawY = 10'(y); blank = blk; frame_tick = tk; anim_start = st;
    @(posedge vga_clk);
    model_edge(x, y, blk, tk, st);
    #1;
    chk("addr_s0", bus0.rom_address, m_addr[0]);
    chk("addr_s1", bus1.rom_address, m_addr[1]);
    chk("opaque_s0", opaque0, m_opq[0]);
    chk("opaque_s1", opaque1, m_opq[1]);
    chk("rgb_s0", {red0, green0, blue0}, m_rgb[0]);
    chk("rgb_s1", {red1, green1, blue1}, m_rgb[1]);
    chk("anim_done", done0, done);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(600, 470, 1, 0, 0);
    Reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(600, 470, 1, 1, 0);
  endtask

  typedef struct {
    int x; int y; bit blk; bit transp; int exp_addr; bit exp_opq;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{100, 50,  1, 0, 0,    1};
    vt[1]  = '{99,  50,  1, 0, 0,    0};
    vt[2]  = '{101, 50,  1, 0, 1,    1};
    vt[3]  = '{139, 50,  1, 0, 39,   1};
    vt[4]  = '{140, 50,  1, 0, 0,    0};
    vt[5]  = '{100, 49,  1, 0, 0,    0};
    vt[6]  = '{100, 51,  1, 0, 40,   1};
    vt[7]  = '{139, 115, 1, 0, 2639, 1};
    vt[8]  = '{100, 116, 1, 0, 0,    0};
    vt[9]  = '{105, 60,  0, 0, 405,  0};
    vt[10] = '{105, 60,  1, 1, 405,  0};
    vt[11] = '{120, 80,  1, 0, 1220, 1};

    // Reset state
    do_reset();
    chk("rst_addr", bus0.rom_address, 0);
    chk("rst_opaque", opaque0, 0);
    chk("rst_rgb", {red0, green0, blue0}, 0);
    chk("rst_done", done0, 0);

    // Table: pos (100,50), frame 0
    sprite_x = 10'd100; sprite_y = 10'd50;
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      force_transp = 1'b0;
      cyc(vt[i].x, vt[i].y, vt[i].blk, 0, 0);
      chk($sformatf("vec%0d_addr", i), bus0.rom_address, vt[i].exp_addr);
      force_transp = vt[i].transp;
      cyc(600, 470, 1, 0, 0);
      chk($sformatf("vec%0d_opq", i), opaque0, vt[i].exp_opq);
      chk($sformatf("vec%0d_rgb", i), {red0, green0, blue0},
          vt[i].exp_opq ? pal_fn(rom_fn(vt[i].exp_addr)) : 12'h0);
      force_transp = 1'b0;
    end

    // Reset mid-frame: black until the next (0,0)
    cyc(100, 50, 1, 0, 0);
    do_reset();
    cyc(120, 80, 1, 0, 0);
    chk("rstmid_addr", bus0.rom_address, 0);
    cyc(600, 470, 1, 0, 0);
    chk("rstmid_opq", opaque0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(120, 80, 1, 0, 0);
    chk("rearm_addr", bus0.rom_address, 1220);

    // 2x scale at (0,0)
    do_reset();
    sprite_x = 10'd0; sprite_y = 10'd0;
    cyc(0, 0, 1, 0, 0); chk("sc_x0", bus1.rom_address, 0);
    cyc(1, 0, 1, 0, 0); chk("sc_x1", bus1.rom_address, 0);
    cyc(2, 0, 1, 0, 0); chk("sc_x2", bus1.rom_address, 1);
    cyc(3, 0, 1, 0, 0); chk("sc_x3", bus1.rom_address, 1);
    cyc(0, 2, 1, 0, 0); chk("sc_y2", bus1.rom_address, 40);

    // Looping animation
    anim_loop = 1'b1;
    cyc(600, 470, 1, 0, 1);
    ticks(12);
    cyc(1, 0, 1, 0, 0); chk("loop_notear", bus0.rom_address, 1);
    cyc(0, 0, 1, 0, 0); chk("loop_f2", bus0.rom_address, 5280);
    ticks(6);
    cyc(0, 0, 1, 0, 0); chk("loop_f3", bus0.rom_address, 7920);
    ticks(6);
    cyc(0, 0, 1, 0, 0); chk("loop_wrap", bus0.rom_address, 0);

    // One-shot animation
    anim_loop = 1'b0;
    cyc(600, 470, 1, 0, 1);
    ticks(17);
    chk("once_notdone", done0, 0);
    ticks(1);
    chk("once_done", done0, 1);
    cyc(0, 0, 1, 0, 0); chk("once_f3", bus0.rom_address, 7920);
    ticks(12);
    cyc(0, 0, 1, 0, 0); chk("once_hold", bus0.rom_address, 7920);
    chk("once_done2", done0, 1);
    cyc(600, 470, 1, 0, 1);
    chk("restart_done", done0, 0);
    cyc(0, 0, 1, 0, 0); chk("restart_f0", bus0.rom_address, 0);
    cyc(600, 470, 1, 1, 1);
    ticks(5);
    cyc(0, 0, 1, 0, 0); chk("starttick_f0", bus0.rom_address, 0);
    ticks(1);
    cyc(0, 0, 1, 0, 0); chk("starttick_f1", bus0.rom_address, 2640);

`ifdef SPRITE_FLIP_EN
    do_reset();
    flip_h = 1'b1;
    cyc(0, 0, 1, 0, 0);  chk("flip_x0", bus0.rom_address, 39);
    cyc(39, 0, 1, 0, 0); chk("flip_x39", bus0.rom_address, 0);
    flip_h = 1'b0;
`endif

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      int x, y;
      sprite_x = 10'($urandom_range(0, 600));
      sprite_y = 10'($urandom_range(0, 440));
      flip_h = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) anim_loop = ~anim_loop;
      force_transp = ($urandom_range(0, 9) == 0);
      Reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) begin
        x = 0; y = 0;
      end else if ($urandom_range(0, 1) == 0) begin
        x = $urandom_range(0, 639); y = $urandom_range(0, 479);
      end else begin
        x = lat_x + $urandom_range(0, 90) - 5;
        y = lat_y + $urandom_range(0, 140) - 5;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
      end
      cyc(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 79) == 0);
    end
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
